lane_scatter_unit: RTL and testbench
====================================

LANE_SCATTER_UNIT -- requirements
Module: lane_scatter_unit

Interface
REQ-001 Parameters SHALL be WARP_SIZE (default 32, warp lane count) and DATA_WIDTH (default 32, lane word width), both taken from pkg_opengpu.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  unit can accept a request.
REQ-006 lane_data  input  WARP_SIZE x DATA_WIDTH  per-lane source words.
REQ-007 dst_idx  input  WARP_SIZE x 5  per-lane destination lane.
REQ-008 active_mask  input  WARP_SIZE  source/destination participation mask.
REQ-009 scat_op  input  1  0 = WRITE, 1 = ADD.
REQ-010 resp_valid  output  1  result available.
REQ-011 resp_ready  input  1  consumer accepts result.
REQ-012 result  output  WARP_SIZE x DATA_WIDTH  per-destination-lane word.
REQ-013 result_valid  output  WARP_SIZE  destination lane received at least one write.
REQ-014 pass_count  output  6  number of scatter passes used (k).

Function
REQ-015 Operation SHALL be a scatter (push): active source lane i delivers lane_data[i] to lane dst_idx[i].
REQ-016 FSM SHALL have states IDLE, BUSY, DONE; req_ready = 1 only in IDLE; resp_valid = 1 only in DONE.
REQ-017 IDLE on req_valid: latch lane_data, dst_idx, active_mask, scat_op; set pending = active_mask; preload result[j] = lane_data[j]; clear result_valid and pass_count.
REQ-018 From IDLE, an accepted request with active_mask = 0 SHALL go directly to DONE; otherwise to BUSY.
REQ-019 Each BUSY cycle SHALL perform one pass: for each destination j, select the lowest-numbered pending source i with dst_idx[i] = j, apply it, and clear pending[i]; increment pass_count.
REQ-020 WRITE: applied source replaces result[j]; after all passes result[j] = data of the highest-numbered active source targeting j.
REQ-021 ADD: the first applied source replaces result[j], later ones add modulo 2^DATA_WIDTH; carry discarded.
REQ-022 Writes to a destination with latched active_mask[j] = 0 SHALL be discarded (source still consumed); result_valid[j] is set only for active j receiving a write.
REQ-023 BUSY SHALL go to DONE on the edge where pending becomes zero.
REQ-024 Latency: resp_valid first high in the cycle after edge (accept + k), where k = maximum number of active sources sharing any destination (k = 0 for empty mask); pass_count = k.
REQ-025 Untargeted lanes SHALL output their own latched lane_data with result_valid = 0.
REQ-026 DONE SHALL hold result, result_valid, pass_count stable until resp_valid && resp_ready, then go to IDLE; no new request is accepted in that cycle.
REQ-027 Input changes after acceptance SHALL have no effect on the in-flight operation.

Reset
REQ-028 rst SHALL take priority over all other events, including mid-BUSY and DONE with resp_ready high.
REQ-029 After reset: state IDLE, req_ready = 1, resp_valid = 0, result = 0, result_valid = 0, pass_count = 0, pending = 0.
REQ-030 An operation interrupted by reset SHALL be abandoned with no response.

Verification
REQ-031 Identity: dst_idx[i] = i, mask all ones, WRITE, lane_data[i] = i -> resp_valid 1 cycle after accept edge, result[i] = i, result_valid all ones, pass_count 1.
REQ-032 Full collision: all 32 lanes -> dst 0, ADD, lane_data[i] = 1 -> pass_count 32, result[0] = 32, result_valid = 0x00000001, other lanes pass through.
REQ-033 WRITE conflict: lanes 3 and 7 -> dst 5 (data 0xA, 0xB), mask 0x000000A8 -> result[5] = 0xB, result_valid = 0x00000020, pass_count 2.
REQ-034 Inactive destination: lane 0 -> dst 1, mask 0x00000001 -> result_valid = 0, result[1] = latched lane_data[1], pass_count 1.
REQ-035 Backpressure and empty mask: mask 0, resp_ready low 5 cycles -> resp_valid held with stable outputs, pass_count 0, req_ready 0 until handshake, IDLE next cycle.
REQ-036 Reset mid-BUSY during a 32-pass ADD -> next cycle IDLE, all outputs zero, no resp_valid pulse.

Source files
------------

// File: rtl/pkg_opengpu.sv
// Shared OpenGPU configuration constants: warp geometry and lane word width.
package pkg_opengpu;
    localparam int WARP_SIZE  = 32;
    localparam int DATA_WIDTH = 32;
endpackage

// File: rtl/lane_scatter_if.sv
// Request/response bundle for the lane scatter unit; master issues scatters, slave executes them.
interface lane_scatter_if #(
    parameter int WARP_SIZE  = pkg_opengpu::WARP_SIZE,
    parameter int DATA_WIDTH = pkg_opengpu::DATA_WIDTH
);
    logic                                  req_valid;
    logic                                  req_ready;
    logic [WARP_SIZE-1:0][DATA_WIDTH-1:0]  lane_data;
    logic [WARP_SIZE-1:0][4:0]             dst_idx;
    logic [WARP_SIZE-1:0]                  active_mask;
    logic                                  scat_op;
    logic                                  resp_valid;
    logic                                  resp_ready;
    logic [WARP_SIZE-1:0][DATA_WIDTH-1:0]  result;
    logic [WARP_SIZE-1:0]                  result_valid;
    logic [5:0]                            pass_count;

    modport master (
        output req_valid, lane_data, dst_idx, active_mask, scat_op, resp_ready,
        input  req_ready, resp_valid, result, result_valid, pass_count
    );

    modport slave (
        input  req_valid, lane_data, dst_idx, active_mask, scat_op, resp_ready,
        output req_ready, resp_valid, result, result_valid, pass_count
    );
endinterface

// File: rtl/lane_scatter_unit.sv
// Warp-wide scatter (push): each active lane delivers its word to a destination lane,
// resolving collisions one source per destination per pass (WRITE keeps last, ADD accumulates).
module lane_scatter_unit #(
    parameter int WARP_SIZE  = pkg_opengpu::WARP_SIZE,
    parameter int DATA_WIDTH = pkg_opengpu::DATA_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    lane_scatter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_next;

    logic [WARP_SIZE-1:0][DATA_WIDTH-1:0] lat_data;
    logic [WARP_SIZE-1:0][4:0]            lat_dst;
    logic [WARP_SIZE-1:0]                 lat_mask;
    logic                                 lat_op;

    logic [WARP_SIZE-1:0]                 pending, pending_next;
    logic [WARP_SIZE-1:0][DATA_WIDTH-1:0] result_q, result_next;
    logic [WARP_SIZE-1:0]                 rv_q, rv_next;
    logic [5:0]                           pass_q;

    assign bus.req_ready    = (state == IDLE);
    assign bus.resp_valid   = (state == DONE);
    assign bus.result       = result_q;
    assign bus.result_valid = rv_q;
    assign bus.pass_count   = pass_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.req_valid)
                    state_next = (bus.active_mask == '0) ? DONE : BUSY;
            end
            BUSY: begin
                if (pending_next == '0)
                    state_next = DONE;
            end
            DONE: begin
                if (bus.resp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // One pass: every destination consumes its lowest-numbered pending source. The
    // destination's result_valid bit doubles as "already written" for ADD accumulation.
    always_comb begin
        logic found;
        pending_next = pending;
        result_next  = result_q;
        rv_next      = rv_q;
        found        = 1'b0;
        for (int j = 0; j < WARP_SIZE; j++) begin
            found = 1'b0;
            for (int i = 0; i < WARP_SIZE; i++) begin
                if (!found && pending[i] && (lat_dst[i] == 5'(j))) begin
                    found           = 1'b1;
                    pending_next[i] = 1'b0;
                    if (lat_mask[j]) begin
                        if (lat_op && rv_q[j])
                            result_next[j] = result_q[j] + lat_data[i];
                        else
                            result_next[j] = lat_data[i];
                        rv_next[j] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_data <= '0;
            lat_dst  <= '0;
            lat_mask <= '0;
            lat_op   <= 1'b0;
            pending  <= '0;
            result_q <= '0;
            rv_q     <= '0;
            pass_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        lat_data <= bus.lane_data;
                        lat_dst  <= bus.dst_idx;
                        lat_mask <= bus.active_mask;
                        lat_op   <= bus.scat_op;
                        pending  <= bus.active_mask;
                        result_q <= bus.lane_data;
                        rv_q     <= '0;
                        pass_q   <= '0;
                    end
                end
                BUSY: begin
                    pending  <= pending_next;
                    result_q <= result_next;
                    rv_q     <= rv_next;
                    pass_q   <= pass_q + 6'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lane_scatter_unit.sv
// Randomized scoreboard bench for lane_scatter_unit against a per-destination reference model.
module tb_lane_scatter_unit;

    localparam int W = 32;
    localparam int D = 32;

    typedef struct {
        logic [W-1:0][D-1:0] result;
        logic [W-1:0]        rv;
        int                  k;
        int                  accept_edge;
        int                  hold;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   finished = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lane_scatter_if #(.WARP_SIZE(W), .DATA_WIDTH(D)) bus ();

    lane_scatter_unit #(.WARP_SIZE(W), .DATA_WIDTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_output(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: each destination sees its targeting sources as a set; WRITE keeps the
    // highest-numbered one, ADD is their wrapped sum; k is the largest such set.
    function automatic exp_t model(input logic [W-1:0][D-1:0] data, input logic [W-1:0][4:0] dst,
                                   input logic [W-1:0] mask, input logic op);
        exp_t        m;
        logic [D-1:0] sum, last;
        int          n;
        m.rv = '0;
        m.k  = 0;
        for (int j = 0; j < W; j++) begin
            sum = '0; last = '0; n = 0;
            for (int i = 0; i < W; i++) begin
                if (mask[i] && int'(dst[i]) == j) begin
                    sum  = sum + data[i];
                    last = data[i];
                    n++;
                end
            end
            if (n > m.k) m.k = n;
            m.result[j] = data[j];
            if (n > 0 && mask[j]) begin
                m.result[j] = op ? sum : last;
                m.rv[j]     = 1'b1;
            end
        end
        m.accept_edge = 0;
        m.hold        = 0;
        return m;
    endfunction

    task automatic scramble_inputs();
        for (int i = 0; i < W; i++) begin
            bus.lane_data[i] = $urandom;
            bus.dst_idx[i]   = 5'($urandom_range(0, 31));
        end
        bus.active_mask = $urandom;
        bus.scat_op     = 1'($urandom_range(0, 1));
    endtask

    task automatic apply_stimulus(input logic [W-1:0][D-1:0] data, input logic [W-1:0][4:0] dst,
                                  input logic [W-1:0] mask, input logic op, input int hold,
                                  input bit expect_resp);
        exp_t e;
        int   waited = 0;
        @(negedge clk);
        while (!bus.req_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready) begin
            check_output("req_ready_timeout", bus.req_ready, 1);
            return;
        end
        bus.lane_data   = data;
        bus.dst_idx     = dst;
        bus.active_mask = mask;
        bus.scat_op     = op;
        bus.req_valid   = 1'b1;
        if (expect_resp) begin
            e             = model(data, dst, mask, op);
            e.accept_edge = cyc + 1;
            e.hold        = hold;
            sb_q.push_back(e);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        scramble_inputs();
    endtask

    task automatic print_summary();
        if (!finished) begin
            finished = 1;
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        end
    endtask

    // Monitor: pops on first sight of resp_valid, then holds the consumer off for the
    // transaction's backpressure window while checking the outputs stay frozen.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check_output("unexpected_resp_valid", bus.resp_valid, 0);
                end else begin
                    e = sb_q.pop_front();
                    check_output("latency", cyc - e.accept_edge, e.k);
                    for (int h = 0; h <= e.hold; h++) begin
                        if (h > 0) @(negedge clk);
                        check_output("resp_valid_held", bus.resp_valid, 1);
                        check_output("req_ready_low", bus.req_ready, 0);
                        check_output("result", bus.result, e.result);
                        check_output("result_valid", bus.result_valid, e.rv);
                        check_output("pass_count", bus.pass_count, e.k);
                        bus.resp_ready = (h == e.hold);
                    end
                    @(negedge clk);
                    bus.resp_ready = 1'b0;
                    check_output("idle_after_handshake", bus.req_ready, 1);
                    check_output("resp_valid_dropped", bus.resp_valid, 0);
                end
            end
        end
    end

    initial begin : watchdog
        repeat (80000) @(posedge clk);
        errors++;
        $display("[TB] FAIL watchdog: got no completion expected finish within 80000 cycles");
        print_summary();
        $finish;
    end

    initial begin : main
        logic [W-1:0][D-1:0] data;
        logic [W-1:0][4:0]   dst;
        logic [W-1:0]        mask;
        int                  sel, t;

        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        scramble_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_req_ready", bus.req_ready, 1);
        check_output("reset_resp_valid", bus.resp_valid, 0);
        check_output("reset_result", bus.result, 0);
        check_output("reset_result_valid", bus.result_valid, 0);
        check_output("reset_pass_count", bus.pass_count, 0);
        rst = 1'b0;

        for (int i = 0; i < W; i++) begin data[i] = D'(i); dst[i] = 5'(i); end
        apply_stimulus(data, dst, '1, 1'b0, 0, 1);

        for (int i = 0; i < W; i++) begin data[i] = 1; dst[i] = 5'd0; end
        apply_stimulus(data, dst, '1, 1'b1, 1, 1);

        for (int i = 0; i < W; i++) begin data[i] = $urandom; dst[i] = 5'd0; end
        data[3] = 32'hA; data[7] = 32'hB; dst[3] = 5'd5; dst[7] = 5'd5;
        apply_stimulus(data, dst, 32'h0000_00A8, 1'b0, 0, 1);

        for (int i = 0; i < W; i++) begin data[i] = $urandom; dst[i] = 5'd0; end
        dst[0] = 5'd1;
        apply_stimulus(data, dst, 32'h0000_0001, 1'b0, 2, 1);

        for (int i = 0; i < W; i++) begin data[i] = $urandom; dst[i] = 5'($urandom_range(0, 31)); end
        apply_stimulus(data, dst, '0, 1'b1, 5, 1);

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 3);
            for (int i = 0; i < W; i++) begin
                data[i] = $urandom;
                dst[i]  = (sel == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            end
            sel  = $urandom_range(0, 5);
            mask = (sel == 0) ? '0 : (sel == 1) ? '1 : W'($urandom);
            apply_stimulus(data, dst, mask, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1);
        end

        t = 0;
        while ((sb_q.size() != 0 || !bus.req_ready) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check_output("drain_queue_empty", sb_q.size(), 0);
        check_output("drain_idle", bus.req_ready, 1);

        // Abandon a long ADD collision mid-flight; no response may ever appear.
        for (int i = 0; i < W; i++) begin data[i] = 1; dst[i] = 5'd0; end
        apply_stimulus(data, dst, '1, 1'b1, 0, 0);
        repeat (10) @(negedge clk);
        check_output("busy_before_reset", bus.req_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("midbusy_reset_req_ready", bus.req_ready, 1);
        check_output("midbusy_reset_resp_valid", bus.resp_valid, 0);
        check_output("midbusy_reset_result", bus.result, 0);
        check_output("midbusy_reset_result_valid", bus.result_valid, 0);
        check_output("midbusy_reset_pass_count", bus.pass_count, 0);
        repeat (40) begin
            @(negedge clk);
            check_output("no_resp_after_reset", bus.resp_valid, 0);
        end

        print_summary();
        $finish;
    end

endmodule
